status_reporter: RTL

Return-path transmitter for the object bank. It watches the 18 per-object `status_o` bits and, whenever one changes or a full dump is requested, sends an `{address, state}` frame back toward the controller. Frames use the same serial `busy`/`ser_data` format as the forward command link, so an existing `deserializer` instance decodes them unchanged on the far end. It sits beside `top`, fed by the `status_o` vector.

---
 rtl/status_link_pkg.sv | 23 ++
 rtl/rr_pick.sv | 43 ++++
 rtl/status_reporter.sv | 127 ++++++++++++
 3 files changed

// File: rtl/status_link_pkg.sv
// Shared definitions for the serial status/command link.
// Holds the frame geometry, the reporter FSM state type and a frame builder
// used by status_reporter (and by the serializer/deserializer pair).
package status_link_pkg;

    localparam int unsigned ADDR_W  = 5;
    localparam int unsigned FRAME_W = ADDR_W + 1;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        GAP
    } srep_state_t;

    typedef logic [FRAME_W-1:0] frame_t;

    // Frame layout: address in the upper bits, state/command in the LSB.
    function automatic frame_t make_frame(input logic [ADDR_W-1:0] addr,
                                          input logic              state);
        return {addr, state};
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: finds the first set request at or above ptr_i, with wrap.
// Ports:
//   req_i     - request vector, one bit per index
//   ptr_i     - search start index (0..N-1)
//   gnt_idx_o - granted index (valid only when gnt_val_o is high)
//   gnt_val_o - at least one request is set
// Purely combinational.
module rr_pick #(
    parameter int unsigned N     = 18,
    parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [IDX_W-1:0] gnt_idx_o,
    output logic             gnt_val_o
);

    logic [N-1:0]     rot;
    logic [IDX_W-1:0] off;
    logic [IDX_W:0]   sum;

    // Rotate so ptr_i sits at bit 0, pick the lowest set bit, rotate back.
    always_comb begin
        rot = '0;
        off = '0;
        for (int unsigned i = 0; i < N; i++) begin
            rot[i] = req_i[IDX_W'((i + 32'(ptr_i) >= N) ? (i + 32'(ptr_i) - N)
                                                        : (i + 32'(ptr_i)))];
        end
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = IDX_W'(i);
            end
        end
        sum = {1'b0, ptr_i} + {1'b0, off};
        if (sum >= (IDX_W + 1)'(N)) begin
            sum = sum - (IDX_W + 1)'(N);
        end
        gnt_idx_o = sum[IDX_W-1:0];
        gnt_val_o = |req_i;
    end

endmodule

// File: rtl/status_reporter.sv
// Return-path transmitter: reports per-object status changes (or a full dump
// on request) as {address, state} serial frames, MSB first, framed by busy_o.
// Ports:
//   clk_i        - system clock
//   rst_i        - synchronous active-low reset
//   status_i     - object status, bit k belongs to address k+1
//   report_req_i - one-cycle pulse, queue a report for every object
//   ser_data_o   - serial frame data (registered)
//   busy_o       - high for FRAME_W cycles per frame (registered)
//   pending_o    - a report is queued or a frame is in flight (flop-derived)
module status_reporter
    import status_link_pkg::*;
#(
    parameter int unsigned OBJ_CNT = 18
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [OBJ_CNT-1:0] status_i,
    input  logic               report_req_i,
    output logic               ser_data_o,
    output logic               busy_o,
    output logic               pending_o
);

    localparam int unsigned IDX_W = (OBJ_CNT > 1) ? $clog2(OBJ_CNT) : 1;
    localparam int unsigned CNT_W = $clog2(FRAME_W);

    srep_state_t        state_q, state_d;
    logic [OBJ_CNT-1:0] snap_q;
    logic [OBJ_CNT-1:0] pend_q, pend_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    frame_t             shreg_q, shreg_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               ser_q, ser_d;

    logic [IDX_W-1:0]   pick_idx;
    logic               pick_val;
    frame_t             load_frame;

    rr_pick #(
        .N     (OBJ_CNT),
        .IDX_W (IDX_W)
    ) u_pick (
        .req_i     (pend_q),
        .ptr_i     (ptr_q),
        .gnt_idx_o (pick_idx),
        .gnt_val_o (pick_val)
    );

    // Next-state and output logic.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        shreg_d    = shreg_q;
        cnt_d      = cnt_q;
        busy_d     = busy_q;
        ser_d      = ser_q;
        pend_d     = pend_q | (status_i ^ snap_q);
        if (report_req_i) begin
            pend_d = '1;
        end
        load_frame = make_frame(ADDR_W'(pick_idx) + ADDR_W'(1), status_i[pick_idx]);

        unique case (state_q)
            // The gap cycle doubles as a load slot so back-to-back frames run
            // at FRAME_W+1 cycles while still leaving one low busy cycle.
            IDLE, GAP: begin
                busy_d  = 1'b0;
                ser_d   = 1'b0;
                state_d = IDLE;
                if (pick_val) begin
                    shreg_d          = load_frame;
                    busy_d           = 1'b1;
                    ser_d            = load_frame[FRAME_W-1];
                    pend_d[pick_idx] = 1'b0;  // clear beats a same-edge change
                    ptr_d            = (pick_idx == IDX_W'(OBJ_CNT - 1)) ? '0
                                                                         : pick_idx + IDX_W'(1);
                    cnt_d            = CNT_W'(FRAME_W - 1);
                    state_d          = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt_q != '0) begin
                    shreg_d = {shreg_q[FRAME_W-2:0], 1'b0};
                    ser_d   = shreg_q[FRAME_W-2];
                    cnt_d   = cnt_q - CNT_W'(1);
                end else begin
                    busy_d  = 1'b0;
                    ser_d   = 1'b0;
                    state_d = GAP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register; snap tracks status_i every edge, including reset.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            snap_q  <= status_i;
            pend_q  <= '0;
            ptr_q   <= '0;
            shreg_q <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            ser_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            snap_q  <= status_i;
            pend_q  <= pend_d;
            ptr_q   <= ptr_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            ser_q   <= ser_d;
        end
    end

    assign ser_data_o = ser_q;
    assign busy_o     = busy_q;
    assign pending_o  = (|pend_q) || (state_q != IDLE);

endmodule
